// File: rtl/gerador_req_ie_pkg.sv
// Shared definitions for the IE request initiator: FSM encodings, function one-hot
// codes and the null-profile constant.
package gerador_req_ie_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReq   = 3'd1,
      StServe = 3'd2,
      StFim   = 3'd3,
      StSolta = 3'd4
   } estado_e;

   localparam logic [2:0] FUN_NENHUMA = 3'b000;
   localparam logic [2:0] FUN_1       = 3'b001;
   localparam logic [2:0] FUN_2       = 3'b010;
   localparam logic [2:0] FUN_3       = 3'b100;
   localparam logic [2:0] PERF_NULO   = 3'b000;

   function automatic logic [2:0] cod_fun(input logic [1:0] vet);
      logic [2:0] fun;
      unique case (vet)
         2'b01:   fun = FUN_1;
         2'b10:   fun = FUN_2;
         2'b11:   fun = FUN_3;
         default: fun = FUN_NENHUMA;
      endcase
      return fun;
   endfunction

endpackage

// File: rtl/gerador_req_ie_if.sv
// Request/switch bundle between one IE initiator (master) and its surroundings
// (switches, buttons and the arbiter, slave side).
interface gerador_req_ie_if;

   logic [2:0] CH_PERF;
   logic       CH_EN;
   logic [1:0] B;
   logic       GRANT;
   logic       REQ_VALID;
   logic [2:0] REQ_PERF;
   logic [2:0] REQ_FUN;
   logic       BUSY;
   logic       DONE;

   modport master (
      input  CH_PERF, CH_EN, B, GRANT,
      output REQ_VALID, REQ_PERF, REQ_FUN, BUSY, DONE
   );

   modport slave (
      output CH_PERF, CH_EN, B, GRANT,
      input  REQ_VALID, REQ_PERF, REQ_FUN, BUSY, DONE
   );

endinterface

// File: rtl/gerador_req_ie_debounce_vet.sv
// debounce_vet: 2-flop synchronizer plus stable-count acceptance of a W-bit vector;
// the output updates only after N consecutive identical synchronized samples.
module gerador_req_ie_debounce_vet #(
   parameter int unsigned W = 2,
   parameter int unsigned N = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   localparam int unsigned CW = $clog2(N);

   logic [W-1:0]  r_s1;
   logic [W-1:0]  r_s2;
   logic [W-1:0]  r_cand;
   logic [W-1:0]  r_q;
   logic [CW-1:0] r_cnt;

   // r_cnt is the number of identical samples seen so far; it parks at N-1.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_cand <= '0;
         r_q    <= '0;
         r_cnt  <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= CW'(1);
         end else if (r_cnt == CW'(N - 1)) begin
            r_q <= r_cand;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/gerador_req_ie.sv
// Request initiator for one IE: debounces buttons, latches profile/function, requests
// the arbiter and holds the request for a fixed granted service time.
module gerador_req_ie
   import gerador_req_ie_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = 50000,
   parameter int unsigned HOLD_CYCLES = 100000000
) (
   input logic              CLK,
   input logic              RST,
   gerador_req_ie_if.master ie
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

   logic          r_en_s1;
   logic          r_en_s2;
   logic [2:0]    r_perf_s1;
   logic [2:0]    r_perf_s2;
   logic [1:0]    w_acc;
   estado_e       r_estado;
   estado_e       w_estado_prox;
   logic [HW-1:0] r_cnt;
   logic [HW-1:0] w_cnt_prox;
   logic          w_latch;
   logic [2:0]    r_req_perf;
   logic [2:0]    r_req_fun;
   logic          r_req_valid;
   logic          r_busy;
   logic          r_done;

   gerador_req_ie_debounce_vet #(
      .W (2),
      .N (DEB_CYCLES)
   ) u_debounce_vet (
      .i_clk (CLK),
      .i_rst (RST),
      .i_d   (ie.B),
      .o_q   (w_acc)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_en_s1   <= 1'b0;
         r_en_s2   <= 1'b0;
         r_perf_s1 <= '0;
         r_perf_s2 <= '0;
      end else begin
         r_en_s1   <= ie.CH_EN;
         r_en_s2   <= r_en_s1;
         r_perf_s1 <= ie.CH_PERF;
         r_perf_s2 <= r_perf_s1;
      end
   end

   always_comb begin
      w_estado_prox = r_estado;
      w_cnt_prox    = r_cnt;
      w_latch       = 1'b0;
      unique case (r_estado)
         StIdle: begin
            if (w_acc != 2'b00) begin
               if (r_en_s2 && (r_perf_s2 != PERF_NULO)) begin
                  w_estado_prox = StReq;
                  w_latch       = 1'b1;
               end else begin
                  w_estado_prox = StSolta;
               end
            end
         end
         StReq: begin
            w_cnt_prox = '0;
            if (!r_en_s2) begin
               w_estado_prox = StSolta;
            end else if (ie.GRANT) begin
               w_estado_prox = StServe;
            end
         end
         StServe: begin
            // Cancel wins over completion; terminal count lands DONE HOLD_CYCLES+1
            // cycles after BUSY rises.
            if (!r_en_s2) begin
               w_estado_prox = StSolta;
               w_cnt_prox    = '0;
            end else if (!ie.GRANT) begin
               w_estado_prox = StReq;
               w_cnt_prox    = '0;
            end else if (r_cnt == HW'(HOLD_CYCLES)) begin
               w_estado_prox = StFim;
               w_cnt_prox    = '0;
            end else begin
               w_cnt_prox = r_cnt + 1'b1;
            end
         end
         StFim: begin
            w_estado_prox = StSolta;
         end
         StSolta: begin
            if (w_acc == 2'b00) begin
               w_estado_prox = StIdle;
            end
         end
         default: begin
            w_estado_prox = StIdle;
            w_cnt_prox    = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they track the FSM without a lag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_estado    <= StIdle;
         r_cnt       <= '0;
         r_req_perf  <= PERF_NULO;
         r_req_fun   <= FUN_NENHUMA;
         r_req_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_estado    <= w_estado_prox;
         r_cnt       <= w_cnt_prox;
         r_req_valid <= (w_estado_prox == StReq) || (w_estado_prox == StServe);
         r_busy      <= (w_estado_prox == StServe);
         r_done      <= (w_estado_prox == StFim);
         if (w_latch) begin
            r_req_perf <= r_perf_s2;
            r_req_fun  <= cod_fun(w_acc);
         end
      end
   end

   assign ie.REQ_VALID = r_req_valid;
   assign ie.REQ_PERF  = r_req_perf;
   assign ie.REQ_FUN   = r_req_fun;
   assign ie.BUSY      = r_busy;
   assign ie.DONE      = r_done;

endmodule
